spi_master: RTL and testbench

Mode-0 SPI controller (CPOL=0, CPHA=0) that drives `sclk`, `cs_n` and `mosi` toward an SPI peripheral and captures `miso`, one `WIDTH`-bit word per transfer. Its SCLK half-period is deliberately long, so a peripheral that synchronizes and debounces its inputs still sees clean edges. It connects to host logic through a start/ready/done handshake and serves as the bench-side and system-side initiator for our SPI peripheral.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_halfperiod_timer.sv | 30 +++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Free-running half-period timer: strobes `last` every HALFPERIOD cycles,
// held at zero while `clear` or `reset` is high.
module spi_halfperiod_timer #(
    parameter int HALFPERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic last
);

    localparam int CW = (HALFPERIOD > 1) ? $clog2(HALFPERIOD) : 1;
    localparam logic [CW-1:0] TERM = CW'(HALFPERIOD - 1);

    logic [CW-1:0] cnt_r;

    // Count up and wrap on the terminal value so each state lasts HALFPERIOD cycles
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == TERM) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign last = (cnt_r == TERM);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one WIDTH-bit word per start/done handshake,
// MSB first, with a long SCLK half-period and a synchronized miso input.
module spi_master #(
    parameter int WIDTH      = 8,
    parameter int HALFPERIOD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    import spi_pkg::*;

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    spi_state_t       state_r;
    logic             ready_r;
    logic             done_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             sclk_r;
    logic             cs_n_r;
    logic             mosi_r;
    logic [WIDTH-1:0] tx_sh_r;
    logic [WIDTH-1:0] rx_sh_r;
    logic [BCW-1:0]   bit_cnt_r;
    logic             miso_meta_r;
    logic             miso_sync_r;
    logic             idle_s;
    logic             last_s;

    assign idle_s = (state_r == IDLE);

    spi_halfperiod_timer #(
        .HALFPERIOD(HALFPERIOD)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(idle_s),
        .last (last_s)
    );

    // Two-flop synchronizer for the asynchronous miso input
    always_ff @(posedge clk) begin
        if (reset) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= miso;
            miso_sync_r <= miso_meta_r;
        end
    end

    // Transfer FSM; every output is registered against the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            rx_data_r <= {WIDTH{1'b0}};
            sclk_r    <= SPI_CPOL;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            tx_sh_r   <= {WIDTH{1'b0}};
            rx_sh_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= SETUP;
                        ready_r   <= 1'b0;
                        cs_n_r    <= 1'b0;
                        mosi_r    <= tx_data[WIDTH-1];
                        tx_sh_r   <= tx_data;
                        rx_sh_r   <= {WIDTH{1'b0}};
                        bit_cnt_r <= {BCW{1'b0}};
                    end
                end
                SETUP: begin
                    if (last_s) begin
                        state_r <= HIGH;
                        sclk_r  <= ~SPI_CPOL;
                    end
                end
                HIGH: begin
                    if (last_s) begin
                        rx_sh_r   <= {rx_sh_r[WIDTH-2:0], miso_sync_r};
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                        sclk_r    <= SPI_CPOL;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= HOLD;
                            mosi_r  <= tx_sh_r[WIDTH-1];
                        end else begin
                            // Next bit goes out on the falling edge, a full half-period before the rise
                            state_r <= LOW;
                            tx_sh_r <= tx_sh_r << 1;
                            mosi_r  <= tx_sh_r[WIDTH-2];
                        end
                    end
                end
                LOW: begin
                    if (last_s) begin
                        state_r <= HIGH;
                        sclk_r  <= ~SPI_CPOL;
                    end
                end
                HOLD: begin
                    if (last_s) begin
                        state_r   <= GAP;
                        cs_n_r    <= 1'b1;
                        mosi_r    <= 1'b0;
                        done_r    <= 1'b1;
                        rx_data_r <= rx_sh_r;
                    end
                end
                GAP: begin
                    if (last_s) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    sclk_r  <= SPI_CPOL;
                    cs_n_r  <= 1'b1;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign sclk    = sclk_r;
    assign cs_n    = cs_n_r;
    assign mosi    = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single transfers on W=8/H=8,
// plus back-to-back, reset, W=2/H=2 corner and H=4 loopback sequences.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       ready, done, sclk, cs_n, mosi, miso;
    logic [7:0] rx_data;

    logic       s_start;
    logic [1:0] s_tx;
    logic       s_ready, s_done, s_sclk, s_cs_n, s_mosi;
    logic [1:0] s_rx;

    logic       l_start;
    logic [7:0] l_tx;
    logic       l_ready, l_done, l_sclk, l_cs_n, l_mosi;
    logic [7:0] l_rx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.WIDTH(8), .HALFPERIOD(8)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .ready(ready), .done(done), .rx_data(rx_data),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.WIDTH(2), .HALFPERIOD(2)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .tx_data(s_tx),
        .ready(s_ready), .done(s_done), .rx_data(s_rx),
        .sclk(s_sclk), .cs_n(s_cs_n), .mosi(s_mosi), .miso(1'b1)
    );

    spi_master #(.WIDTH(8), .HALFPERIOD(4)) dut_loop (
        .clk(clk), .reset(reset), .start(l_start), .tx_data(l_tx),
        .ready(l_ready), .done(l_done), .rx_data(l_rx),
        .sclk(l_sclk), .cs_n(l_cs_n), .mosi(l_mosi), .miso(l_mosi)
    );

    // Mode-0 peripheral: loads its word on cs_n fall, shifts on each sclk fall
    logic [7:0] per_word = 8'h00;
    logic [7:0] per_sh = 8'h00;
    logic       cs_prev = 1'b1;
    logic       sclk_prev = 1'b0;
    always @(posedge clk) begin
        cs_prev   <= cs_n;
        sclk_prev <= sclk;
        if (cs_prev && !cs_n) per_sh <= per_word;
        else if (sclk_prev && !sclk) per_sh <= {per_sh[6:0], 1'b0};
    end
    assign miso = per_sh[7];

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  per;
        logic [7:0]  poke;
        logic [7:0]  exp_mosi;
        logic [7:0]  exp_rx;
        logic [15:0] exp_done;
        logic [15:0] exp_ready;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int pulses, hiw, badw, badm, ndone, done_at, ready_at, extra;
        logic [7:0] mbits, rxv;
        logic prev_sclk, rise_mosi;
        pulses = 0; hiw = 0; badw = 0; badm = 0; ndone = 0; extra = 0;
        done_at = -1; ready_at = -1; mbits = 8'h00; rxv = 8'h00;
        prev_sclk = 1'b0; rise_mosi = 1'b0;
        per_word = v.per;
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", idx), 32'(ready), 32'd1);
        start = 1'b1;
        tx_data = v.tx;
        for (int i = 1; i <= 200 && ready_at < 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                tx_data = ~v.tx;
                check($sformatf("v%0d_t1_cs_n", idx), 32'(cs_n), 32'd0);
                check($sformatf("v%0d_t1_ready", idx), 32'(ready), 32'd0);
                check($sformatf("v%0d_t1_mosi", idx), 32'(mosi), 32'(v.exp_mosi[7]));
            end
            if (v.poke != 8'd0 && i == int'(v.poke)) begin
                start = 1'b1;
                tx_data = 8'h11;
            end
            if (v.poke != 8'd0 && i == int'(v.poke) + 1) start = 1'b0;
            if (sclk && !prev_sclk) begin
                mbits = {mbits[6:0], mosi};
                rise_mosi = mosi;
                pulses++;
                hiw = 0;
            end
            if (sclk) begin
                hiw++;
                if (mosi !== rise_mosi) badm++;
            end
            if (!sclk && prev_sclk && hiw != 8) badw++;
            prev_sclk = sclk;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = i;
                    rxv = rx_data;
                end
            end
            if (ready) ready_at = i;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (!cs_n || done) extra++;
        end
        check($sformatf("v%0d_mosi_stream", idx), 32'(mbits), 32'(v.exp_mosi));
        check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'd8);
        check($sformatf("v%0d_bad_high_width", idx), 32'(badw), 32'd0);
        check($sformatf("v%0d_mosi_moved_high", idx), 32'(badm), 32'd0);
        check($sformatf("v%0d_done_at", idx), 32'(done_at), 32'(v.exp_done));
        check($sformatf("v%0d_done_count", idx), 32'(ndone), 32'd1);
        check($sformatf("v%0d_rx_data", idx), 32'(rxv), 32'(v.exp_rx));
        check($sformatf("v%0d_ready_at", idx), 32'(ready_at), 32'(v.exp_ready));
        check($sformatf("v%0d_extra_activity", idx), 32'(extra), 32'd0);
    endtask

    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rise_at, fall2, nd, spur, done1, done2, pulses, cs_low, done_at, ready_at;
        logic [7:0] rx1, rx2, prev_rx, mb;
        logic prev_cs, prev_sc;

        // tx, peripheral word, busy poke cycle, expected mosi, expected rx, done, ready
        vecs[0] = '{8'hA5, 8'h3C, 8'd0,  8'hA5, 8'h3C, 16'd137, 16'd145};
        vecs[1] = '{8'h80, 8'h5A, 8'd20, 8'h80, 8'h5A, 16'd137, 16'd145};
        vecs[2] = '{8'h00, 8'hFF, 8'd0,  8'h00, 8'hFF, 16'd137, 16'd145};
        vecs[3] = '{8'h96, 8'h69, 8'd0,  8'h96, 8'h69, 16'd137, 16'd145};

        reset = 1'b1; start = 1'b0; tx_data = 8'h00;
        s_start = 1'b0; s_tx = 2'b00; l_start = 1'b0; l_tx = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);

        // Reset and start together: the start is dropped
        start = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_cs_n", 32'(cs_n), 32'd1);
        check("rst_start_ready", 32'(ready), 32'd1);

        for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

        // Back-to-back transfers with start held high
        per_word = 8'h33;
        rise_at = -1; fall2 = -1; nd = 0; spur = 0; done1 = -1; done2 = -1;
        rx1 = 8'h00; rx2 = 8'h00; mb = 8'h00;
        prev_rx = rx_data; prev_cs = cs_n; prev_sc = sclk;
        @(negedge clk);
        start = 1'b1; tx_data = 8'hFF;
        for (int i = 1; i <= 400 && nd < 2; i++) begin
            @(negedge clk);
            tx_data = 8'h00;
            if (rx_data !== prev_rx && !done) spur++;
            prev_rx = rx_data;
            if (cs_n && !prev_cs && rise_at < 0) rise_at = i;
            if (!cs_n && prev_cs && rise_at >= 0) fall2 = i;
            prev_cs = cs_n;
            if (sclk && !prev_sc) mb = {mb[6:0], mosi};
            prev_sc = sclk;
            if (done) begin
                nd++;
                if (nd == 1) begin done1 = i; rx1 = rx_data; per_word = 8'hC6; end
                else begin done2 = i; rx2 = rx_data; start = 1'b0; end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
        check("b2b_cs_gap", 32'(fall2 - rise_at), 32'd9);
        check("b2b_done_count", 32'(nd), 32'd2);
        check("b2b_done1_at", 32'(done1), 32'd137);
        check("b2b_done2_at", 32'(done2), 32'd282);
        check("b2b_rx1", 32'(rx1), 32'h33);
        check("b2b_rx2", 32'(rx2), 32'hC6);
        check("b2b_second_mosi", 32'(mb), 32'h00);
        check("b2b_rx_spurious", 32'(spur), 32'd0);

        // Reset in the middle of a transfer
        per_word = 8'hFF; nd = 0;
        @(negedge clk);
        start = 1'b1; tx_data = 8'hC3;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        if (done) nd++;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'd0);
        run_vec('{8'h5A, 8'hA5, 8'd0, 8'h5A, 8'hA5, 16'd137, 16'd145}, 4);

        // W=2, H=2 corner with miso tied high
        pulses = 0; cs_low = 0; done_at = -1; rx1 = 8'h00; mb = 8'h00; prev_sc = 1'b0;
        @(negedge clk);
        s_start = 1'b1; s_tx = 2'b10;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            s_start = 1'b0; s_tx = 2'b01;
            if (!s_cs_n) cs_low++;
            if (s_sclk && !prev_sc) begin mb = {mb[6:0], s_mosi}; pulses++; end
            prev_sc = s_sclk;
            if (s_done && done_at < 0) begin done_at = i; rx1 = {6'd0, s_rx}; end
        end
        check("small_done_at", 32'(done_at), 32'd11);
        check("small_rx", 32'(rx1), 32'd3);
        check("small_cs_low", 32'(cs_low), 32'd10);
        check("small_mosi", 32'(mb), 32'd2);
        check("small_pulses", 32'(pulses), 32'd2);

        // Loopback on H=4
        done_at = -1; ready_at = -1; rx1 = 8'h00;
        @(negedge clk);
        l_start = 1'b1; l_tx = 8'hC3;
        for (int i = 1; i <= 120 && ready_at < 0; i++) begin
            @(negedge clk);
            l_start = 1'b0; l_tx = 8'h00;
            if (l_done && done_at < 0) begin done_at = i; rx1 = l_rx; end
            if (l_ready) ready_at = i;
        end
        check("loop_done_at", 32'(done_at), 32'd69);
        check("loop_rx", 32'(rx1), 32'hC3);
        check("loop_ready_at", 32'(ready_at), 32'd73);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
